multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control unit for the multicycle variant of the ARM-subset processor. It sits directly upstream of the datapath. It takes the latched instruction fields and the main ALU flags, and it drives every datapath select and write enable. Internally it holds the sequencing FSM, the NZCV flags register, and a per-instruction latched condition result.

## Interface
Parameters: none.
- clock  in  1  single system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- Instr  in  20  instruction register bits [31:12] (cond[31:28], op[27:26], funct[25:20], Rd[15:12])
- Z, N, C, V  in  1 each  combinational flags from the main ALU
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  unified memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = register B, 01 = ExtImm, 10 = constant 4
- ALUControl  out  1  0 = add, 1 = subtract
- ImmSrc  out  2  00 = imm8, 01 = imm12, 10 = imm24
- RegSrc  out  2  same meaning as in the single-cycle datapath: bit0 selects R15 for RA1 (branch), bit1 selects Rd for RA2 (store)
- Flags  out  4  registered {N,Z,C,V}

## Operation
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=0, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE
  - Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. No write enables.
  - Latches CondEx from cond and the current Flags.
  - Next state by op/funct:
    - op=01 → MEMADR
    - op=00 and funct[5]=0 → EXECR
    - op=00 and funct[5]=1 → EXECI
    - op=10 → BRANCH
    - op=11 → FETCH (undefined instruction, treated as NOP)
- MEMADR
  - Outputs: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, add.
  - Next state: funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Next state: FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondEx, RegSrc[1]=1. Next state: FETCH.
- EXECR / EXECI
  - Outputs: ALUSrcA=0. ALUSrcB=00 in EXECR, 01 in EXECI (with ImmSrc=00).
  - ALUControl from funct[4:1]: 0100 ADD → 0; 0010 SUB → 1; 1010 CMP → 1. Any other cmd is unsupported.
  - Next state: ALUWB.
- ALUWB
  - Output: ResultSrc=00.
  - RegWrite = CondEx & supported & not CMP.
- BRANCH
  - Outputs: ALUSrcA=0, RegSrc[0]=1, ALUSrcB=01, ImmSrc=10, add, ResultSrc=10.
  - PCWrite=CondEx.
  - Next state: FETCH.
- PC write via Rd=15: in MEMWB/ALUWB, if Rd=15 and the register write would be enabled, assert PCWrite as well.
- Flags update:
  - Flags ← {N,Z,C,V} at the end of EXECR/EXECI when CondEx & supported & (funct[0]=1 or CMP).
  - Otherwise Flags are held.
- Condition codes, evaluated on registered Flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 → 0
- CondEx is registered in DECODE and held until the next DECODE. An instruction's own flag update never alters its own write gating.
- Non-executed instructions traverse the same states with all gated enables held at 0.
- Unsupported DP cmds: no RegWrite, no flag update.

## Timing
- Cycles per instruction (FETCH through the last state):
  - LDR: 5
  - STR: 4
  - DP: 4
  - B: 3
  - undefined: 2
- All outputs are a function of state, the Instr fields, and CondEx. There is no combinational path from Z/N/C/V to any output.
- Reset:
  - While reset_n=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 combinationally.
  - On the first edge with reset_n=0: state ← FETCH, Flags ← 0000, CondEx ← 0.
  - The first cycle with reset_n=1 is FETCH.
- Reset asserted mid-instruction abandons the instruction. No write enable is asserted after the reset edge.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → all write enables 0, Flags=0000. Release → first cycle IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcB=10.
- ADD immediate: Instr=0xE2821005 (ADD R1,R2,#5) → FETCH, DECODE, EXECI (ALUSrcB=01, ImmSrc=00, ALUControl=0), ALUWB (RegWrite=1), then FETCH. 4 cycles.
- CMP then branch:
  - Instr=0xE1510001 (CMP R1,R1) with Z=1,C=1 driven in EXECR → Flags=0110, no RegWrite in ALUWB.
  - Then 0x0A000002 (BEQ) → BRANCH with PCWrite=1.
  - Repeat with Flags Z=0 → PCWrite=0 in BRANCH.
- Load and store:
  - 0xE5921004 (LDR) → MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1). 5 cycles.
  - 0xE5821004 (STR) → MEMWR with MemWrite=1, RegSrc[1]=1. 4 cycles.
- Latched condition: Flags Z=0, Instr=0x10500000 (SUBNES R0,R0,R0), ALU drives Z=1 in EXECR → Flags Z becomes 1, yet ALUWB RegWrite=1.
- Boundaries:
  - reset_n=0 during MEMRD of an LDR → no RegWrite; next state after release is FETCH.
  - Instr op=11 → FETCH, DECODE, FETCH with no enables beyond FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath.
// Latency: n/a (wires only). Backpressure: none, the controller is free-running.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [19:0] Instr;
    logic        Z;
    logic        N;
    logic        C;
    logic        V;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [3:0]  Flags;

    modport master (
        input  Instr, Z, N, C, V,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags
    );

    modport slave (
        output Instr, Z, N, C, V,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multicycle ARM-subset core: drives all datapath selects/enables, owns NZCV.
// Latency: 5/4/4/3/2 cycles per LDR/STR/DP/B/undefined instruction, outputs depend only on registered state.
// Backpressure: none; the datapath must complete every step in one cycle.
module multicycle_ctrl (
    input  logic              clock,
    input  logic              reset_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [3:0] flags;
    logic       condex;
    logic       cond_pass;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign cmd       = funct[4:1];
    assign unused_rn = ^bus.Instr[7:4];

    logic dp_supported;
    logic dp_cmp;
    logic dp_sub;
    logic dp_wr;
    logic rd_pc;

    assign dp_cmp       = (cmd == CMD_CMP);
    assign dp_sub       = (cmd == CMD_SUB) || dp_cmp;
    assign dp_supported = (cmd == CMD_ADD) || dp_sub;
    assign dp_wr        = condex && dp_supported && !dp_cmp;
    assign rd_pc        = (rd == 4'd15);

    // Condition evaluated on the registered flags {N,Z,C,V}, never on the live ALU flags
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flags[2];
            4'b0001: cond_pass = !flags[2];
            4'b0010: cond_pass = flags[1];
            4'b0011: cond_pass = !flags[1];
            4'b0100: cond_pass = flags[3];
            4'b0101: cond_pass = !flags[3];
            4'b0110: cond_pass = flags[0];
            4'b0111: cond_pass = !flags[0];
            4'b1000: cond_pass = flags[1] && !flags[2];
            4'b1001: cond_pass = !flags[1] || flags[2];
            4'b1010: cond_pass = (flags[3] == flags[0]);
            4'b1011: cond_pass = (flags[3] != flags[0]);
            4'b1100: cond_pass = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_pass = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   state_nxt = MEMADR;
                    2'b00:   state_nxt = funct[5] ? EXECI : EXECR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: state_nxt = funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_nxt = MEMWB;
            EXECR:  state_nxt = ALUWB;
            EXECI:  state_nxt = ALUWB;
            default: state_nxt = FETCH;
        endcase
    end

    logic       pcw;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       adr;
    logic [1:0] rs;
    logic       asa;
    logic [1:0] asb;
    logic       alc;
    logic [1:0] imm;
    logic [1:0] rsrc;

    always_comb begin
        pcw  = 1'b0;
        mw   = 1'b0;
        irw  = 1'b0;
        rw   = 1'b0;
        adr  = 1'b0;
        rs   = 2'b00;
        asa  = 1'b0;
        asb  = 2'b00;
        alc  = 1'b0;
        imm  = 2'b00;
        rsrc = 2'b00;
        case (state)
            FETCH: begin
                irw = 1'b1;
                pcw = 1'b1;
                asa = 1'b1;
                asb = 2'b10;
                rs  = 2'b10;
            end
            DECODE: begin
                asa = 1'b1;
                asb = 2'b10;
                rs  = 2'b10;
            end
            MEMADR: begin
                asb = 2'b01;
                imm = 2'b01;
            end
            MEMRD:  adr = 1'b1;
            MEMWB: begin
                rs  = 2'b01;
                rw  = condex;
                pcw = condex && rd_pc;
            end
            MEMWR: begin
                adr  = 1'b1;
                mw   = condex;
                rsrc = 2'b10;
            end
            EXECR:  alc = dp_sub;
            EXECI: begin
                asb = 2'b01;
                alc = dp_sub;
            end
            ALUWB: begin
                rw  = dp_wr;
                pcw = dp_wr && rd_pc;
            end
            BRANCH: begin
                rsrc = 2'b01;
                asb  = 2'b01;
                imm  = 2'b10;
                rs   = 2'b10;
                pcw  = condex;
            end
            default: ;
        endcase
    end

    // Write enables are masked by reset so nothing commits while reset is held
    assign bus.PCWrite    = reset_n && pcw;
    assign bus.MemWrite   = reset_n && mw;
    assign bus.IRWrite    = reset_n && irw;
    assign bus.RegWrite   = reset_n && rw;
    assign bus.AdrSrc     = adr;
    assign bus.ResultSrc  = rs;
    assign bus.ALUSrcA    = asa;
    assign bus.ALUSrcB    = asb;
    assign bus.ALUControl = alc;
    assign bus.ImmSrc     = imm;
    assign bus.RegSrc     = rsrc;
    assign bus.Flags      = flags;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= FETCH;
            flags  <= 4'b0000;
            condex <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DECODE)
                condex <= cond_pass;
            if ((state == EXECR || state == EXECI) && condex && dp_supported && (funct[0] || dp_cmp))
                flags <= {bus.N, bus.Z, bus.C, bus.V};
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // control word layout: pcw adr mw irw rw rs[1:0] asa asb[1:0] alc imm[1:0] rsrc[1:0]
    localparam logic [14:0] M_WE  = 15'h5C00;
    localparam logic [14:0] M_ADR = 15'h2000;
    localparam logic [14:0] M_RS  = 15'h0300;
    localparam logic [14:0] M_ASA = 15'h0080;
    localparam logic [14:0] M_ASB = 15'h0060;
    localparam logic [14:0] M_ALC = 15'h0010;
    localparam logic [14:0] M_IMM = 15'h000C;
    localparam logic [14:0] M_RG1 = 15'h0002;
    localparam logic [14:0] M_RG0 = 15'h0001;

    int n_chk = 0;
    int n_err = 0;
    logic [3:0] mflags = 4'b0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] cw(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic asa, input logic [1:0] asb, input logic alc,
                                       input logic [1:0] imm, input logic [1:0] rsrc);
        return {pcw, adr, mw, irw, rw, rs, asa, asb, alc, imm, rsrc};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
    endfunction

    // ARM condition table on flags {N,Z,C,V}
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one instruction starting in its fetch cycle (entered just after a rising edge).
    // abort_at >= 0 asserts reset during that cycle and abandons the instruction.
    task automatic run_instr(input logic [31:0] ins, input bit force_alu, input logic [3:0] alu_set,
                             input int abort_at);
        logic [14:0] ew[$];
        logic [14:0] em[$];
        logic [1:0]  op;
        logic [3:0]  cmd;
        bit ce, sup, cmp, sbit, ibit, lbit, rd15, upd, wr;
        int exec_idx;
        logic [3:0] alu;
        op   = ins[27:26];
        cmd  = ins[24:21];
        ibit = ins[25];
        sbit = ins[20];
        lbit = ins[20];
        rd15 = (ins[15:12] == 4'd15);
        ce   = cond_holds(ins[31:28], mflags);
        sup  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        cmp  = (cmd == 4'b1010);
        wr   = ce && sup && !cmp;
        upd  = 1'b0;
        exec_idx = -1;

        ew.push_back(cw(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 0, 2'b00, 2'b00));
        em.push_back(M_WE | M_ADR | M_RS | M_ASA | M_ASB | M_ALC);
        ew.push_back(cw(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 0, 2'b00, 2'b00));
        em.push_back(M_WE | M_RS | M_ASA | M_ASB);
        case (op)
            2'b01: begin
                ew.push_back(cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 2'b01, 2'b00));
                em.push_back(M_WE | M_ASA | M_ASB | M_ALC | M_IMM);
                if (lbit) begin
                    ew.push_back(cw(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00));
                    em.push_back(M_WE | M_ADR | M_RS);
                    ew.push_back(cw(ce && rd15, 0, 0, 0, ce, 2'b01, 0, 2'b00, 0, 2'b00, 2'b00));
                    em.push_back(M_WE | M_RS);
                end else begin
                    ew.push_back(cw(0, 1, ce, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b10));
                    em.push_back(M_WE | M_ADR | M_RS | M_RG1);
                end
            end
            2'b00: begin
                exec_idx = 2;
                upd = ce && sup && (sbit || cmp);
                ew.push_back(cw(0, 0, 0, 0, 0, 2'b00, 0, ibit ? 2'b01 : 2'b00, cmd != 4'b0100,
                                2'b00, 2'b00));
                em.push_back(M_WE | M_ASA | M_ASB | (ibit ? M_IMM : 15'h0) | (sup ? M_ALC : 15'h0));
                ew.push_back(cw(wr && rd15, 0, 0, 0, wr, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00));
                em.push_back(M_WE | M_RS);
            end
            2'b10: begin
                ew.push_back(cw(ce, 0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 2'b10, 2'b01));
                em.push_back(M_WE | M_ASA | M_ASB | M_ALC | M_IMM | M_RS | M_RG0);
            end
            default: ;
        endcase

        for (int k = 0; k < ew.size(); k++) begin
            if (k == 0)
                bus.Instr = ins[31:12];
            alu = force_alu ? alu_set : 4'($urandom_range(0, 15));
            {bus.N, bus.Z, bus.C, bus.V} = alu;
            if (k == abort_at)
                reset_n = 1'b0;
            @(negedge clock);
            if (k == abort_at) begin
                check("abort_we", 32'(observed() & M_WE), 32'h0);
                @(posedge clock);
                #1;
                mflags  = 4'b0000;
                reset_n = 1'b1;
                check("abort_flags", 32'(bus.Flags), 32'h0);
                return;
            end
            check($sformatf("ins%08h_cyc%0d", ins, k), 32'(observed() & em[k]), 32'(ew[k] & em[k]));
            check($sformatf("ins%08h_flags%0d", ins, k), 32'(bus.Flags), 32'(mflags));
            @(posedge clock);
            #1;
            if (k == exec_idx && upd)
                mflags = alu;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [31:0] r;
        r     = $urandom;
        cond  = ($urandom_range(0, 2) == 0) ? 4'he : 4'($urandom_range(0, 15));
        op    = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        funct = 6'($urandom_range(0, 63));
        if (op == 2'b00) begin
            case ($urandom_range(0, 3))
                0: funct[4:1] = 4'b0100;
                1: funct[4:1] = 4'b0010;
                2: funct[4:1] = 4'b1010;
                default: ;
            endcase
        end
        rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
        return {cond, op, funct, r[15:12], rd, r[11:0]};
    endfunction

    initial begin
        bus.Instr = 20'h0;
        {bus.N, bus.Z, bus.C, bus.V} = 4'b0000;
        reset_n = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            {bus.N, bus.Z, bus.C, bus.V} = 4'($urandom_range(0, 15));
            @(negedge clock);
            check("reset_we", 32'(observed() & M_WE), 32'h0);
            check("reset_flags", 32'(bus.Flags), 32'h0);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        run_instr(32'hE2821005, 1'b0, 4'b0000, -1);   // ADD R1,R2,#5
        run_instr(32'hE1510001, 1'b1, 4'b0110, -1);   // CMP R1,R1 with Z=1,C=1
        check("cmp_flags", 32'(bus.Flags), 32'h6);
        run_instr(32'h0A000002, 1'b0, 4'b0000, -1);   // BEQ taken
        run_instr(32'hE1510001, 1'b1, 4'b0010, -1);   // CMP leaving Z=0
        check("cmp_flags_nz", 32'(bus.Flags), 32'h2);
        run_instr(32'h0A000002, 1'b0, 4'b0000, -1);   // BEQ not taken
        run_instr(32'hE5921004, 1'b0, 4'b0000, -1);   // LDR
        run_instr(32'hE5821004, 1'b0, 4'b0000, -1);   // STR
        run_instr(32'h10500000, 1'b1, 4'b0100, -1);   // SUBNES, ALU reports Z=1
        check("subnes_flags", 32'(bus.Flags), 32'h4);
        run_instr(32'hE5921004, 1'b0, 4'b0000, 3);    // LDR abandoned in MEMRD
        run_instr(32'hEC000000, 1'b0, 4'b0000, -1);   // undefined op=11

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                run_instr(rand_instr(), 1'b0, 4'b0000, $urandom_range(0, 2));
            else
                run_instr(rand_instr(), 1'b0, 4'b0000, -1);
        end
        run_instr(32'hE2821005, 1'b0, 4'b0000, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
